flight_request_sequencer: RTL and testbench
===========================================

// Module: flight_request_sequencer
// PURPOSE
//   Initiator side of the AirTrafficControl request/allocation interface.
//   Queues landing and takeoff requests from the radar/gate front end and offers them one at a time to the controller.
//   Receives the runway allocation for each offered request and tracks per-runway occupancy until the runway is clear.
//   Sits between the aircraft-side inputs and the AirTrafficControl core.
// PARAMETERS
//   DEPTH          4   normal-priority FIFO entries (power of 2, >=2)
//   GRANT_TIMEOUT  15  cycles WAIT_GRANT waits before abandoning the request (max 15)
//   OCCUPY_CYCLES  12  cycles a granted runway stays busy (1..15)
// PORTS
//   clk            in   1  rising-edge clock
//   rst_n          in   1  synchronous reset, active low
//   in_valid       in   1  new request present
//   in_ready       out  1  request accepted when in_valid & in_ready
//   in_takeoff     in   1  1 = takeoff, 0 = landing
//   in_emergency   in   1  emergency request
//   in_fuel        in   2  fuel code, same encoding as controller fuel
//   in_gate        in   3  gate number (takeoff) / requested gate (landing)
//   atc_valid      out  1  request offered to controller
//   atc_ready      in   1  controller takes request when atc_valid & atc_ready
//   atc_takeoff    out  1  offered request fields, stable while atc_valid
//   atc_emergency  out  1
//   atc_fuel       out  2
//   atc_gate       out  3
//   grant_valid    in   1  one-cycle allocation strobe from controller
//   grant_runway   in   2  allocated runway index
//   runway_busy    out  4  bit r = runway r occupied
//   queue_count    out  3  normal FIFO occupancy (0..DEPTH)
//   timeout_pulse  out  1  one-cycle: request abandoned after GRANT_TIMEOUT
//   conflict_pulse out  1  one-cycle: grant named a busy runway
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): FIFO and emergency slot emptied, FSM->IDLE, all counters 0.
//   All outputs 0 except in_ready, which is 1 from the first cycle after reset.
//   Intake, emergency: in_emergency=1 goes to a 1-entry emergency slot.
//     in_ready = slot empty.
//   Intake, normal: goes to the FIFO. in_ready = queue_count<DEPTH.
//     Push while full is impossible because in_ready=0.
//   FSM states: IDLE, OFFER, WAIT_GRANT.
//     IDLE->OFFER when the emergency slot or FIFO is non-empty.
//       The entry is popped into the offer register. Emergency slot wins.
//       atc_valid rises the cycle after the pop (1-cycle latency).
//     OFFER: hold atc_valid and fields until atc_ready=1, then go to WAIT_GRANT.
//       Clear the wait counter on entry.
//     WAIT_GRANT, grant_valid=1 with runway_busy[grant_runway]=0:
//       set busy bit, load that runway counter with OCCUPY_CYCLES, go to IDLE.
//     WAIT_GRANT, grant_valid=1 on a busy runway:
//       conflict_pulse=1, no state change, request re-offered (go to OFFER).
//     WAIT_GRANT, counter reaches GRANT_TIMEOUT:
//       timeout_pulse=1, request dropped, go to IDLE.
//     grant_valid outside WAIT_GRANT is ignored.
//   Runway counters: four independent 4-bit down counters.
//     Each decrements every cycle while non-zero.
//     Busy bit clears on the cycle the counter goes 1->0.
//     No wrap: a counter at 0 stays 0.
//   Simultaneous events:
//     Push and pop of the same FIFO in one cycle is legal; count unchanged.
//     A release and a new grant on the same runway in one cycle: the grant sees busy=1 and conflicts.
//   Pointers are log2(DEPTH) bits and wrap. queue_count is derived separately, not from pointer difference.
//   Reset mid-offer or mid-wait abandons the request with no pulse.
// STRUCTURE
//   Shared package atc_pkg holds:
//     fsm state localparams (IDLE/OFFER/WAIT_GRANT)
//     fuel codes
//     NUM_RUNWAYS=4
//     request field widths
//   One sub-module: runway_occupancy_timer, one instance per runway (busy bit + 4-bit counter).
//   FIFO is inline.
// TESTING
//   1 Reset: hold rst_n=0 for 2 clk -> all outputs 0, in_ready=1 after release.
//   2 Push landing {fuel=01,gate=010}, atc_ready=1, grant runway 2 two cycles later
//     -> atc_valid high for 1 cycle, runway_busy=0100 for exactly 12 cycles.
//   3 Queue 2 normal requests, then 1 emergency
//     -> emergency offered first, normal ones follow in FIFO order.
//   4 4 pushes with atc_ready=0 -> queue_count=4, in_ready=0.
//     5th in_valid is held off and is accepted once an entry pops.
//   5 Grant runway 1 while runway_busy[1]=1 -> conflict_pulse=1 for 1 cycle, same request re-offered.
//   6 atc_ready=1, then no grant for 15 cycles -> timeout_pulse=1, FSM returns to IDLE, next entry offered.

Source files
------------

// File: rtl/atc_pkg.sv
// Shared definitions for the AirTrafficControl request/allocation path.
package atc_pkg;

  localparam int NUM_RUNWAYS = 4;
  localparam int RUNWAY_W    = 2;
  localparam int FUEL_W      = 2;
  localparam int GATE_W      = 3;
  localparam int CNT_W       = 4;

  // Fuel codes, shared with the controller
  localparam logic [FUEL_W-1:0] FUEL_CRITICAL = 2'd0;
  localparam logic [FUEL_W-1:0] FUEL_LOW      = 2'd1;
  localparam logic [FUEL_W-1:0] FUEL_NORMAL   = 2'd2;
  localparam logic [FUEL_W-1:0] FUEL_FULL     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OFFER      = 2'd1,
    ST_WAIT_GRANT = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic              takeoff;
    logic              emergency;
    logic [FUEL_W-1:0] fuel;
    logic [GATE_W-1:0] gate;
  } req_t;

endpackage

// File: rtl/runway_occupancy_timer.sv
// One runway: busy flag plus a down counter loaded on a successful grant.
module runway_occupancy_timer
  import atc_pkg::*;
#(
  parameter int OCCUPY_CYCLES = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(OCCUPY_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Load on grant, then count down to zero; busy drops on the 1->0 step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= LOAD_VAL;
      busy <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/flight_request_sequencer.sv
// Initiator side of the ATC interface: queues requests, offers them to the
// controller one at a time and tracks runway occupancy after allocation.
module flight_request_sequencer
  import atc_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int GRANT_TIMEOUT = 15,
  parameter int OCCUPY_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_takeoff,
  input  logic       in_emergency,
  input  logic [1:0] in_fuel,
  input  logic [2:0] in_gate,
  output logic       atc_valid,
  input  logic       atc_ready,
  output logic       atc_takeoff,
  output logic       atc_emergency,
  output logic [1:0] atc_fuel,
  output logic [2:0] atc_gate,
  input  logic       grant_valid,
  input  logic [1:0] grant_runway,
  output logic [3:0] runway_busy,
  output logic [2:0] queue_count,
  output logic       timeout_pulse,
  output logic       conflict_pulse
);

  localparam int          PTR_W     = $clog2(DEPTH);
  localparam logic [2:0]  DEPTH_C   = 3'(DEPTH);
  localparam logic [3:0]  WAIT_LAST = 4'(GRANT_TIMEOUT - 1);

  req_t             fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [2:0]       count;
  req_t             emg_slot;
  logic             emg_full;
  req_t             offer;
  seq_state_t       state;
  logic [3:0]       wait_cnt;

  req_t in_req;
  logic push_emg, push_norm, pop_emg, pop_norm, grant_ok;

  assign in_req = '{takeoff: in_takeoff, emergency: in_emergency,
                    fuel: in_fuel, gate: in_gate};

  // Intake handshake and pop/grant qualifiers; emergency slot has priority
  always_comb begin
    in_ready  = in_emergency ? ~emg_full : (count != DEPTH_C);
    push_emg  = in_valid & in_ready & in_emergency;
    push_norm = in_valid & in_ready & ~in_emergency;
    pop_emg   = (state == ST_IDLE) & emg_full;
    pop_norm  = (state == ST_IDLE) & ~emg_full & (count != 3'd0);
    grant_ok  = (state == ST_WAIT_GRANT) & grant_valid & ~runway_busy[grant_runway];
  end

  assign queue_count   = count;
  assign atc_takeoff   = offer.takeoff;
  assign atc_emergency = offer.emergency;
  assign atc_fuel      = offer.fuel;
  assign atc_gate      = offer.gate;

  // Request storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_norm) fifo_mem[wr_ptr] <= in_req;
    if (push_emg)  emg_slot         <= in_req;
  end

  // FIFO pointers, occupancy and emergency slot flag; count tracked separately
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      emg_full <= 1'b0;
    end else begin
      if (push_norm) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_norm)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_norm, pop_norm})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push_emg)     emg_full <= 1'b1;
      else if (pop_emg) emg_full <= 1'b0;
    end
  end

  // Offer/allocation FSM with registered handshake and event pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      atc_valid      <= 1'b0;
      offer          <= '0;
      wait_cnt       <= '0;
      timeout_pulse  <= 1'b0;
      conflict_pulse <= 1'b0;
    end else begin
      timeout_pulse  <= 1'b0;
      conflict_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop_emg) begin
            offer     <= emg_slot;
            atc_valid <= 1'b1;
            state     <= ST_OFFER;
          end else if (pop_norm) begin
            offer     <= fifo_mem[rd_ptr];
            atc_valid <= 1'b1;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (atc_ready) begin
            atc_valid <= 1'b0;
            wait_cnt  <= '0;
            state     <= ST_WAIT_GRANT;
          end
        end
        ST_WAIT_GRANT: begin
          if (grant_valid) begin
            if (grant_ok) begin
              state <= ST_IDLE;
            end else begin
              conflict_pulse <= 1'b1;
              atc_valid      <= 1'b1;
              state          <= ST_OFFER;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_pulse <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < NUM_RUNWAYS; r++) begin : g_runway
    runway_occupancy_timer #(
      .OCCUPY_CYCLES(OCCUPY_CYCLES)
    ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (grant_ok && (grant_runway == RUNWAY_W'(r))),
      .busy (runway_busy[r])
    );
  end

endmodule

// File: tb/tb_flight_request_sequencer.sv
// Directed bench for flight_request_sequencer.
module tb_flight_request_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_takeoff, in_emergency;
  logic [1:0] in_fuel;
  logic [2:0] in_gate;
  logic       atc_valid, atc_ready, atc_takeoff, atc_emergency;
  logic [1:0] atc_fuel;
  logic [2:0] atc_gate;
  logic       grant_valid;
  logic [1:0] grant_runway;
  logic [3:0] runway_busy;
  logic [2:0] queue_count;
  logic       timeout_pulse, conflict_pulse;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flight_request_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_takeoff    (in_takeoff),
    .in_emergency  (in_emergency),
    .in_fuel       (in_fuel),
    .in_gate       (in_gate),
    .atc_valid     (atc_valid),
    .atc_ready     (atc_ready),
    .atc_takeoff   (atc_takeoff),
    .atc_emergency (atc_emergency),
    .atc_fuel      (atc_fuel),
    .atc_gate      (atc_gate),
    .grant_valid   (grant_valid),
    .grant_runway  (grant_runway),
    .runway_busy   (runway_busy),
    .queue_count   (queue_count),
    .timeout_pulse (timeout_pulse),
    .conflict_pulse(conflict_pulse)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic to, input logic em, input logic [1:0] fu, input logic [2:0] ga);
    in_valid = 1'b1; in_takeoff = to; in_emergency = em; in_fuel = fu; in_gate = ga;
    check_eq("push_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; in_emergency = 1'b0;
  endtask

  // Accept the current offer, then grant it a runway on the next cycle
  task automatic accept_and_grant(input logic [1:0] rw);
    atc_ready = 1'b1;
    tick();
    atc_ready = 1'b0;
    grant_valid = 1'b1; grant_runway = rw;
    tick();
    grant_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_takeoff = 1'b0; in_emergency = 1'b0;
    in_fuel = 2'd0; in_gate = 3'd0; atc_ready = 1'b0; grant_valid = 1'b0; grant_runway = 2'd0;

    // 1: reset
    @(negedge clk);
    tick(); tick();
    check_eq("rst_atc_valid", atc_valid, 1'b0);
    check_eq("rst_fields", {atc_takeoff, atc_emergency, atc_fuel, atc_gate}, 7'd0);
    check_eq("rst_busy", runway_busy, 4'd0);
    check_eq("rst_qcount", queue_count, 3'd0);
    check_eq("rst_pulses", {timeout_pulse, conflict_pulse}, 2'b00);
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", in_ready, 1'b1);

    // 2: single landing, runway 2 occupied for 12 cycles
    atc_ready = 1'b1;
    push(1'b0, 1'b0, 2'b01, 3'b010);
    check_eq("t2_qcount", queue_count, 3'd1);
    tick();
    check_eq("t2_valid", atc_valid, 1'b1);
    check_eq("t2_fields", {atc_takeoff, atc_emergency, atc_fuel, atc_gate}, {1'b0, 1'b0, 2'b01, 3'b010});
    check_eq("t2_qempty", queue_count, 3'd0);
    tick();
    atc_ready = 1'b0;
    check_eq("t2_valid_drop", atc_valid, 1'b0);
    grant_valid = 1'b1; grant_runway = 2'd2;
    tick();
    grant_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check_eq("t2_busy", runway_busy, 4'b0100);
      tick();
    end
    check_eq("t2_released", runway_busy, 4'b0000);

    // 3: emergency overtakes queued normal requests
    push(1'b1, 1'b0, 2'b10, 3'd3);   // D, offered right away and held
    push(1'b0, 1'b0, 2'b00, 3'd1);   // N1
    push(1'b0, 1'b0, 2'b11, 3'd2);   // N2
    push(1'b0, 1'b1, 2'b00, 3'd7);   // E
    check_eq("t3_d_offer", {atc_valid, atc_takeoff, atc_gate}, {1'b1, 1'b1, 3'd3});
    check_eq("t3_qcount", queue_count, 3'd2);
    grant_valid = 1'b1; grant_runway = 2'd0;   // not waiting: ignored
    tick();
    grant_valid = 1'b0;
    check_eq("t3_ign_grant", runway_busy, 4'b0000);
    check_eq("t3_still_offer", atc_valid, 1'b1);
    accept_and_grant(2'd0);
    tick();
    check_eq("t3_emg_first", {atc_valid, atc_emergency, atc_gate}, {1'b1, 1'b1, 3'd7});
    accept_and_grant(2'd1);
    tick();
    check_eq("t3_n1", {atc_valid, atc_emergency, atc_gate}, {1'b1, 1'b0, 3'd1});
    accept_and_grant(2'd2);
    tick();
    check_eq("t3_n2", {atc_valid, atc_fuel, atc_gate}, {1'b1, 2'b11, 3'd2});
    accept_and_grant(2'd3);
    check_eq("t3_qdrained", queue_count, 3'd0);
    check_eq("t3_all_busy", runway_busy, 4'b1111);

    // 5: grant on busy runway 1 -> conflict and re-offer
    push(1'b1, 1'b0, 2'b01, 3'd5);
    tick();
    check_eq("t5_offer", {atc_valid, atc_gate}, {1'b1, 3'd5});
    atc_ready = 1'b1;
    tick();
    atc_ready = 1'b0;
    grant_valid = 1'b1; grant_runway = 2'd1;
    tick();
    grant_valid = 1'b0;
    check_eq("t5_conflict", conflict_pulse, 1'b1);
    check_eq("t5_reoffer", {atc_valid, atc_gate}, {1'b1, 3'd5});
    tick();
    check_eq("t5_conflict_1cyc", conflict_pulse, 1'b0);
    check_eq("t5_still_offer", atc_valid, 1'b1);

    // 6: accepted but never granted -> timeout after 15 cycles
    atc_ready = 1'b1;
    tick();
    atc_ready = 1'b0;
    push(1'b0, 1'b0, 2'b10, 3'd6);   // Q, waits in the FIFO
    for (int i = 0; i < 13; i++) begin
      check_eq("t6_no_early_to", timeout_pulse, 1'b0);
      tick();
    end
    check_eq("t6_no_early_to", timeout_pulse, 1'b0);
    tick();
    check_eq("t6_timeout", timeout_pulse, 1'b1);
    check_eq("t6_idle", atc_valid, 1'b0);
    tick();
    check_eq("t6_timeout_1cyc", timeout_pulse, 1'b0);
    check_eq("t6_next", {atc_valid, atc_gate}, {1'b1, 3'd6});
    check_eq("t6_qempty", queue_count, 3'd0);

    // 4: fill the FIFO, hold off a 5th request until a pop
    push(1'b0, 1'b0, 2'b00, 3'd1);
    push(1'b0, 1'b0, 2'b00, 3'd2);
    push(1'b0, 1'b0, 2'b00, 3'd3);
    push(1'b0, 1'b0, 2'b00, 3'd4);
    check_eq("t4_full", queue_count, 3'd4);
    check_eq("t4_not_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_emergency = 1'b0; in_gate = 3'd7; in_fuel = 2'b11;
    tick();
    check_eq("t4_held_off", queue_count, 3'd4);
    atc_ready = 1'b1;
    tick();
    atc_ready = 1'b0;
    grant_valid = 1'b1; grant_runway = 2'd0;
    tick();
    grant_valid = 1'b0;
    check_eq("t4_still_full", {in_ready, queue_count}, {1'b0, 3'd4});
    tick();
    check_eq("t4_popped", {in_ready, queue_count}, {1'b1, 3'd3});
    check_eq("t4_fifo_head", {atc_valid, atc_gate}, {1'b1, 3'd1});
    tick();
    in_valid = 1'b0;
    check_eq("t4_accepted", queue_count, 3'd4);
    check_eq("t4_rw0_busy", runway_busy[0], 1'b1);

    // Reset while an offer is pending abandons it silently
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rst2_valid", atc_valid, 1'b0);
    check_eq("rst2_state", {queue_count, runway_busy, timeout_pulse, conflict_pulse}, 9'd0);
    tick();
    check_eq("rst2_in_ready", in_ready, 1'b1);
    check_eq("rst2_no_offer", atc_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
